hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipeline_pkg.sv | 37 +++
 rtl/forward_sel.sv | 26 ++
 rtl/hazard_ctrl.sv | 103 ++++++++++
 tb/tb_hazard_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types for hazard control: shadow slots,
// bubble constants and operand forwarding encodings.
package pipeline_pkg;

   typedef struct packed {
      logic       wb_en;
      logic [3:0] dest;
      logic       mem_r;
   } slot_t;

   typedef struct packed {
      slot_t      s;
      logic       use1;
      logic       use2;
      logic [3:0] src1;
      logic [3:0] src2;
   } exe_slot_t;

   localparam slot_t     SLOT_BUBBLE = '0;
   localparam exe_slot_t EXE_BUBBLE  = '0;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   localparam logic [15:0] STALL_MAX = 16'hFFFF;

   function automatic logic src_hit(
      input logic       use_x,
      input logic [3:0] src,
      input logic       wb_en,
      input logic [3:0] dest
   );
      return use_x & wb_en & (src == dest);
   endfunction

endpackage

// File: rtl/forward_sel.sv
// Operand forwarding select for one EXE source;
// a MEM-stage producer is younger and wins over WB.
module forward_sel
   import pipeline_pkg::*;
(
   input  logic       fwd_en,
   input  logic       use_x,
   input  logic [3:0] src,
   input  logic       mem_wb_en,
   input  logic [3:0] mem_dest,
   input  logic       wb_wb_en,
   input  logic [3:0] wb_dest,
   output logic [1:0] sel
);

   always_comb begin
      sel = FWD_RF;
      if (fwd_en) begin
         if (src_hit(use_x, src, mem_wb_en, mem_dest))
            sel = FWD_MEM;
         else if (src_hit(use_x, src, wb_wb_en, wb_dest))
            sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation,
// forwarding selects and a saturating stall counter.
module hazard_ctrl
   import pipeline_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        fwd_en,
   input  logic [3:0]  id_src1,
   input  logic [3:0]  id_src2,
   input  logic        id_use_src1,
   input  logic        id_use_src2,
   input  logic        id_wb_en,
   input  logic [3:0]  id_dest,
   input  logic        id_mem_r_en,
   input  logic        branch_taken,
   input  logic        stat_clr,
   output logic        freeze,
   output logic        if_flush,
   output logic        id_flush,
   output logic [1:0]  fwd_sel1,
   output logic [1:0]  fwd_sel2,
   output logic [15:0] stall_count
);

   exe_slot_t   exe_q, exe_d;
   slot_t       mem_q, mem_d;
   slot_t       wb_q, wb_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic exe_hit, mem_hit, hazard;

   always_comb begin
      exe_hit = src_hit(id_use_src1, id_src1, exe_q.s.wb_en, exe_q.s.dest)
              | src_hit(id_use_src2, id_src2, exe_q.s.wb_en, exe_q.s.dest);
      mem_hit = src_hit(id_use_src1, id_src1, mem_q.wb_en, mem_q.dest)
              | src_hit(id_use_src2, id_src2, mem_q.wb_en, mem_q.dest);
      // With forwarding only a load in EXE cannot be bypassed in time
      hazard = fwd_en ? (exe_hit & exe_q.s.mem_r) : (exe_hit | mem_hit);

      freeze   = hazard & ~branch_taken;
      if_flush = branch_taken;
      id_flush = hazard | branch_taken;

      exe_d = EXE_BUBBLE;
      if (!id_flush) begin
         exe_d.s.wb_en = id_wb_en;
         exe_d.s.dest  = id_dest;
         exe_d.s.mem_r = id_mem_r_en;
         exe_d.use1    = id_use_src1;
         exe_d.use2    = id_use_src2;
         exe_d.src1    = id_src1;
         exe_d.src2    = id_src2;
      end
      mem_d = exe_q.s;
      wb_d  = mem_q;

      stall_cnt_d = stall_cnt_q;
      if (stat_clr)
         stall_cnt_d = '0;
      else if (freeze && stall_cnt_q != STALL_MAX)
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exe_q       <= EXE_BUBBLE;
         mem_q       <= SLOT_BUBBLE;
         wb_q        <= SLOT_BUBBLE;
         stall_cnt_q <= '0;
      end else begin
         exe_q       <= exe_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;

   forward_sel u_fwd1 (
      .fwd_en    (fwd_en),
      .use_x     (exe_q.use1),
      .src       (exe_q.src1),
      .mem_wb_en (mem_q.wb_en),
      .mem_dest  (mem_q.dest),
      .wb_wb_en  (wb_q.wb_en),
      .wb_dest   (wb_q.dest),
      .sel       (fwd_sel1)
   );

   forward_sel u_fwd2 (
      .fwd_en    (fwd_en),
      .use_x     (exe_q.use2),
      .src       (exe_q.src2),
      .mem_wb_en (mem_q.wb_en),
      .mem_dest  (mem_q.dest),
      .wb_wb_en  (wb_q.wb_en),
      .wb_dest   (wb_q.dest),
      .sel       (fwd_sel2)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random
// traffic against an instruction-level pipeline model.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        fwd_en = 1'b0;
   logic [3:0]  id_src1 = '0, id_src2 = '0, id_dest = '0;
   logic        id_use_src1 = 1'b0, id_use_src2 = 1'b0;
   logic        id_wb_en = 1'b0, id_mem_r_en = 1'b0;
   logic        branch_taken = 1'b0, stat_clr = 1'b0;
   logic        freeze, if_flush, id_flush;
   logic [1:0]  fwd_sel1, fwd_sel2;
   logic [15:0] stall_count;

   int n_run = 0;
   int n_fail = 0;

   typedef struct {
      bit wb;
      bit ld;
      bit u1;
      bit u2;
      int dest;
      int s1;
      int s2;
   } ins_t;

   ins_t pipe[3];
   ins_t cur;
   ins_t bub;
   int   m_cnt;

   hazard_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .fwd_en       (fwd_en),
      .id_src1      (id_src1),
      .id_src2      (id_src2),
      .id_use_src1  (id_use_src1),
      .id_use_src2  (id_use_src2),
      .id_wb_en     (id_wb_en),
      .id_dest      (id_dest),
      .id_mem_r_en  (id_mem_r_en),
      .branch_taken (branch_taken),
      .stat_clr     (stat_clr),
      .freeze       (freeze),
      .if_flush     (if_flush),
      .id_flush     (id_flush),
      .fwd_sel1     (fwd_sel1),
      .fwd_sel2     (fwd_sel2),
      .stall_count  (stall_count)
   );

   always #5 clk = ~clk;

   function automatic ins_t mk(bit wb, int dest, bit ld,
                               bit u1, int s1, bit u2, int s2);
      ins_t i;
      i.wb = wb; i.dest = dest; i.ld = ld;
      i.u1 = u1; i.s1 = s1; i.u2 = u2; i.s2 = s2;
      return i;
   endfunction

   // does instruction r read a register that producer p writes
   function automatic bit depends(ins_t r, ins_t p);
      if (!p.wb) return 1'b0;
      return (r.u1 && r.s1 == p.dest) || (r.u2 && r.s2 == p.dest);
   endfunction

   function automatic bit must_stall();
      if (fwd_en) return depends(cur, pipe[0]) && pipe[0].ld;
      return depends(cur, pipe[0]) || depends(cur, pipe[1]);
   endfunction

   function automatic int want_sel(bit u, int s);
      if (!fwd_en || !u) return 0;
      if (pipe[1].wb && pipe[1].dest == s) return 1;
      if (pipe[2].wb && pipe[2].dest == s) return 2;
      return 0;
   endfunction

   task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_id(ins_t i);
      cur = i;
      id_wb_en = i.wb;
      id_dest = 4'(i.dest);
      id_mem_r_en = i.ld;
      id_use_src1 = i.u1;
      id_src1 = 4'(i.s1);
      id_use_src2 = i.u2;
      id_src2 = 4'(i.s2);
   endtask

   task automatic clear_model();
      for (int k = 0; k < 3; k++) pipe[k] = bub;
      m_cnt = 0;
   endtask

   // check all outputs, then advance one clock with the model
   task automatic step(string tag);
      bit h;
      #1;
      h = must_stall();
      chk({tag, "_freeze"}, 16'(freeze), 16'(h && !branch_taken));
      chk({tag, "_if_flush"}, 16'(if_flush), 16'(branch_taken));
      chk({tag, "_id_flush"}, 16'(id_flush), 16'(h || branch_taken));
      chk({tag, "_sel1"}, 16'(fwd_sel1), 16'(want_sel(pipe[0].u1, pipe[0].s1)));
      chk({tag, "_sel2"}, 16'(fwd_sel2), 16'(want_sel(pipe[0].u2, pipe[0].s2)));
      chk({tag, "_count"}, stall_count, 16'(m_cnt));
      @(posedge clk);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (h || branch_taken) ? bub : cur;
      if (stat_clr) m_cnt = 0;
      else if (h && !branch_taken && m_cnt < 65535) m_cnt++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_model();
      @(negedge clk);
      rst = 1'b1;
   endtask

   function automatic int rreg();
      int r = $urandom_range(0, 4);
      return (r == 4) ? 15 : r;
   endfunction

   initial begin
      clear_model();
      set_id(bub);
      // reset state, with and without a branch
      #2;
      chk("rst_freeze", 16'(freeze), 16'd0);
      chk("rst_count", stall_count, 16'd0);
      chk("rst_sel1", 16'(fwd_sel1), 16'd0);
      chk("rst_sel2", 16'(fwd_sel2), 16'd0);
      branch_taken = 1'b1;
      #1;
      chk("rst_if_flush", 16'(if_flush), 16'd1);
      chk("rst_id_flush", 16'(id_flush), 16'd1);
      chk("rst_freeze_br", 16'(freeze), 16'd0);
      @(negedge clk);
      branch_taken = 1'b0;
      rst = 1'b1;

      // forwarding: load R3 then reader of R3
      fwd_en = 1'b1;
      set_id(mk(1, 3, 1, 0, 0, 0, 0));
      step("lu_a");
      set_id(mk(1, 4, 0, 1, 3, 0, 0));
      #1;
      chk("lu_freeze", 16'(freeze), 16'd1);
      chk("lu_id_flush", 16'(id_flush), 16'd1);
      step("lu_b");
      #1;
      chk("lu_freeze_end", 16'(freeze), 16'd0);
      step("lu_c");
      set_id(bub);
      #1;
      chk("lu_sel1", 16'(fwd_sel1), 16'd2);
      chk("lu_count", stall_count, 16'd1);
      step("lu_d");

      // stall-only: ALU write R5 then reader
      do_reset();
      fwd_en = 1'b0;
      set_id(mk(1, 5, 0, 0, 0, 0, 0));
      step("so_a");
      set_id(mk(1, 6, 0, 1, 5, 0, 0));
      #1;
      chk("so_freeze1", 16'(freeze), 16'd1);
      step("so_b");
      #1;
      chk("so_freeze2", 16'(freeze), 16'd1);
      step("so_c");
      #1;
      chk("so_freeze3", 16'(freeze), 16'd0);
      step("so_d");
      set_id(bub);
      #1;
      chk("so_sel1", 16'(fwd_sel1), 16'd0);
      chk("so_count", stall_count, 16'd2);
      step("so_e");

      // forwarding: ALU write R7, reader in Rm, R15 boundary on Rn
      do_reset();
      fwd_en = 1'b1;
      set_id(mk(1, 7, 0, 0, 0, 0, 0));
      step("fw_a");
      set_id(mk(1, 8, 0, 1, 15, 1, 7));
      #1;
      chk("fw_freeze", 16'(freeze), 16'd0);
      step("fw_b");
      set_id(bub);
      #1;
      chk("fw_sel2", 16'(fwd_sel2), 16'd1);
      chk("fw_sel1", 16'(fwd_sel1), 16'd0);
      step("fw_c");

      // branch wins over load-use
      set_id(mk(1, 9, 1, 0, 0, 0, 0));
      step("br_a");
      set_id(mk(1, 10, 0, 1, 9, 0, 0));
      branch_taken = 1'b1;
      #1;
      chk("br_freeze", 16'(freeze), 16'd0);
      chk("br_if_flush", 16'(if_flush), 16'd1);
      chk("br_id_flush", 16'(id_flush), 16'd1);
      step("br_b");
      branch_taken = 1'b0;
      set_id(bub);
      #1;
      chk("br_bubble_sel1", 16'(fwd_sel1), 16'd0);
      step("br_c");

      // saturation and clear
      do_reset();
      fwd_en = 1'b0;
      force dut.stall_cnt_q = 16'hFFFE;
      #1;
      release dut.stall_cnt_q;
      m_cnt = 16'hFFFE;
      set_id(mk(1, 1, 0, 1, 1, 0, 0));
      for (int k = 0; k < 5; k++) step("sat");
      #1;
      chk("sat_hold", stall_count, 16'hFFFF);
      stat_clr = 1'b1;
      #1;
      chk("clr_freeze", 16'(freeze), 16'd1);
      step("clr");
      stat_clr = 1'b0;
      #1;
      chk("clr_count", stall_count, 16'd0);

      // async reset mid-stall
      do_reset();
      fwd_en = 1'b0;
      set_id(mk(1, 5, 0, 0, 0, 0, 0));
      step("ar_a");
      set_id(mk(1, 6, 0, 0, 0, 1, 5));
      #1;
      chk("ar_freeze_pre", 16'(freeze), 16'd1);
      rst = 1'b0;
      clear_model();
      #1;
      chk("ar_freeze_async", 16'(freeze), 16'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("ar_no_stall", 16'(freeze), 16'd0);
      step("ar_b");

      // random traffic
      do_reset();
      for (int c = 0; c < 800; c++) begin
         if (c % 64 == 0) fwd_en = 1'($urandom_range(0, 1));
         branch_taken = ($urandom_range(0, 7) == 0);
         stat_clr = ($urandom_range(0, 31) == 0);
         set_id(mk(1'($urandom_range(0, 1)), rreg(),
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), rreg(),
                   1'($urandom_range(0, 1)), rreg()));
         step("rnd");
      end
      branch_taken = 1'b0;
      stat_clr = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
